// File: rtl/game_score_ctrl.sv
// game_score_ctrl: round controller for the catch-the-fruit game.
// Owns the round FSM (idle/play/pause/win/lose) together with the saturating
// score, the lives count, the difficulty level and the countdown timer.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, pause             one-cycle button pulses
//   gain_valid, gain_amt     catch event and points to add
//   pen_valid, pen_amt       penalty event and points to subtract
//   miss                     item dropped, costs one life
//   state                    IDLE=0 PLAY=1 PAUSE=2 WIN=3 LOSE=4
//   score, lives, level      registered game values
//   time_left                remaining timer ticks
//   level_up, round_end      one-cycle registered pulses
module game_score_ctrl #(
  parameter int unsigned SCORE_W    = 6,
  parameter int unsigned WIN_SCORE  = 30,
  parameter int unsigned LIVES      = 3,
  parameter int unsigned TIME_LIMIT = 60,
  parameter int unsigned TICK_DIV   = 100000000,
  parameter int unsigned LEVEL_STEP = 10,
  parameter int unsigned MAX_LEVEL  = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  input  logic               gain_valid,
  input  logic [3:0]         gain_amt,
  input  logic               pen_valid,
  input  logic [3:0]         pen_amt,
  input  logic               miss,
  output logic [2:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         lives,
  output logic [2:0]         level,
  output logic [7:0]         time_left,
  output logic               level_up,
  output logic               round_end
);

  localparam int unsigned NetW = SCORE_W + 2;
  localparam int unsigned PreW = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPlay  = 3'd1,
    StPause = 3'd2,
    StWin   = 3'd3,
    StLose  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0]         lives_q, lives_d;
  logic [2:0]         level_q, level_d;
  logic [7:0]         time_q, time_d;
  logic [PreW-1:0]    pre_q, pre_d;
  logic               level_up_q, level_up_d;
  logic               round_end_q, round_end_d;

  // Datapath for one PLAY cycle, evaluated unconditionally.
  logic [NetW-1:0]    gain_ext, pen_ext, net;
  logic               underflow, win, lose, dead, tick, timeout;
  logic [SCORE_W-1:0] play_score;
  logic [31:0]        quot;
  logic [2:0]         score_level;

  always_comb begin
    gain_ext = gain_valid ? NetW'(gain_amt) : '0;
    pen_ext  = pen_valid  ? NetW'(pen_amt)  : '0;
    // Two guard bits: the MSB is the sign of the two's-complement result.
    net       = NetW'(score_q) + gain_ext - pen_ext;
    underflow = net[NetW-1];
    win       = !underflow && (net >= NetW'(WIN_SCORE));
    if (underflow) begin
      play_score = '0;
    end else if (win) begin
      play_score = SCORE_W'(WIN_SCORE);
    end else begin
      play_score = net[SCORE_W-1:0];
    end

    quot        = 32'(play_score) / 32'(LEVEL_STEP);
    score_level = (quot > 32'(MAX_LEVEL)) ? 3'(MAX_LEVEL) : quot[2:0];

    // Simultaneous miss and underflow still cost a single life.
    lose = miss | underflow;
    dead = lose && (lives_q == 4'd1);

    tick    = (pre_q == PreW'(TICK_DIV - 1));
    timeout = tick && (time_q == 8'd1);
  end

  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    lives_d     = lives_q;
    level_d     = level_q;
    time_d      = time_q;
    pre_d       = pre_q;
    level_up_d  = 1'b0;
    round_end_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StPlay;
          score_d = '0;
          lives_d = 4'(LIVES);
          level_d = '0;
          time_d  = 8'(TIME_LIMIT);
          pre_d   = '0;
        end
      end

      StPlay: begin
        score_d = play_score;
        if (lose && (lives_q != 4'd0)) begin
          lives_d = lives_q - 4'd1;
        end
        // Level only ratchets upward within a round.
        if (score_level > level_q) begin
          level_d    = score_level;
          level_up_d = 1'b1;
        end
        if (tick) begin
          pre_d  = '0;
          time_d = time_q - 8'd1;
        end else begin
          pre_d = pre_q + PreW'(1);
        end
        // End conditions beat a simultaneous pause; win beats lose.
        if (win) begin
          state_d     = StWin;
          round_end_d = 1'b1;
        end else if (dead || timeout) begin
          state_d     = StLose;
          round_end_d = 1'b1;
        end else if (pause) begin
          state_d = StPause;
        end
      end

      StPause: begin
        if (pause) begin
          state_d = StPlay;
        end else if (start) begin
          state_d = StIdle;
        end
      end

      StWin, StLose: begin
        if (start) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      score_q     <= '0;
      lives_q     <= 4'(LIVES);
      level_q     <= '0;
      time_q      <= 8'(TIME_LIMIT);
      pre_q       <= '0;
      level_up_q  <= 1'b0;
      round_end_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      level_q     <= level_d;
      time_q      <= time_d;
      pre_q       <= pre_d;
      level_up_q  <= level_up_d;
      round_end_q <= round_end_d;
    end
  end

  assign state     = state_q;
  assign score     = score_q;
  assign lives     = lives_q;
  assign level     = level_q;
  assign time_left = time_q;
  assign level_up  = level_up_q;
  assign round_end = round_end_q;

endmodule

// File: tb/tb_game_score_ctrl.sv
// tb_game_score_ctrl: self-checking bench for game_score_ctrl.
// Directed table vectors, hand-written corner sequences and a randomized
// phase, every cycle also compared against an integer reference model.
module tb_game_score_ctrl;

  localparam int SW  = 6;
  localparam int WIN = 30;
  localparam int NL  = 3;
  localparam int TL  = 5;
  localparam int TD  = 4;
  localparam int LS  = 10;
  localparam int ML  = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, pause = 1'b0, gain_valid = 1'b0, pen_valid = 1'b0, miss = 1'b0;
  logic [3:0]    gain_amt = '0, pen_amt = '0;
  logic [2:0]    state;
  logic [SW-1:0] score;
  logic [3:0]    lives;
  logic [2:0]    level;
  logic [7:0]    time_left;
  logic          level_up, round_end;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_state, m_score, m_lives, m_level, m_time, m_pre, m_lu, m_re;

  typedef struct {
    logic       st;
    logic       pz;
    logic       gv;
    logic [3:0] ga;
    logic       pv;
    logic [3:0] pn;
    logic       mi;
    int         e_state;
    int         e_score;
    int         e_lives;
    int         e_level;
    int         e_time;
    int         e_lu;
    int         e_re;
  } vec_t;

  vec_t tbl[12];

  game_score_ctrl #(
    .SCORE_W   (SW),
    .WIN_SCORE (WIN),
    .LIVES     (NL),
    .TIME_LIMIT(TL),
    .TICK_DIV  (TD),
    .LEVEL_STEP(LS),
    .MAX_LEVEL (ML)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pause     (pause),
    .gain_valid(gain_valid),
    .gain_amt  (gain_amt),
    .pen_valid (pen_valid),
    .pen_amt   (pen_amt),
    .miss      (miss),
    .state     (state),
    .score     (score),
    .lives     (lives),
    .level     (level),
    .time_left (time_left),
    .level_up  (level_up),
    .round_end (round_end)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int es, input int esc, input int el,
                         input int elv, input int et, input int elu, input int ere);
    chk({tag, ".state"}, 32'(state), es);
    chk({tag, ".score"}, 32'(score), esc);
    chk({tag, ".lives"}, 32'(lives), el);
    chk({tag, ".level"}, 32'(level), elv);
    chk({tag, ".time_left"}, 32'(time_left), et);
    chk({tag, ".level_up"}, 32'(level_up), elu);
    chk({tag, ".round_end"}, 32'(round_end), ere);
  endtask

  task automatic model_reset();
    m_state = 0; m_score = 0; m_lives = NL; m_level = 0;
    m_time  = TL; m_pre = 0; m_lu = 0; m_re = 0;
  endtask

  // Game rules written directly as integer arithmetic.
  task automatic model_step(input logic s, input logic p, input logic gv, input logic [3:0] ga,
                            input logic pv, input logic [3:0] pn, input logic mi);
    int net, nl;
    bit won, dead, to, uf;
    m_lu = 0;
    m_re = 0;
    case (m_state)
      0: if (s) begin
        m_state = 1; m_score = 0; m_lives = NL; m_level = 0; m_time = TL; m_pre = 0;
      end
      1: begin
        net = m_score + (gv ? int'(ga) : 0) - (pv ? int'(pn) : 0);
        uf  = (net < 0);
        won = (net >= WIN);
        m_score = uf ? 0 : (won ? WIN : net);
        dead = 1'b0;
        if ((mi || uf) && m_lives > 0) begin
          m_lives--;
          dead = (m_lives == 0);
        end
        nl = m_score / LS;
        if (nl > ML) nl = ML;
        if (nl > m_level) begin
          m_level = nl;
          m_lu = 1;
        end
        to = 1'b0;
        if (m_pre == TD - 1) begin
          m_pre = 0;
          m_time--;
          to = (m_time == 0);
        end else begin
          m_pre++;
        end
        if (won) begin
          m_state = 3; m_re = 1;
        end else if (dead || to) begin
          m_state = 4; m_re = 1;
        end else if (p) begin
          m_state = 2;
        end
      end
      2: if (p) m_state = 1; else if (s) m_state = 0;
      default: if (s) m_state = 0;
    endcase
  endtask

  task automatic step(input logic s, input logic p, input logic gv, input logic [3:0] ga,
                      input logic pv, input logic [3:0] pn, input logic mi);
    start = s; pause = p; gain_valid = gv; gain_amt = ga;
    pen_valid = pv; pen_amt = pn; miss = mi;
    @(posedge clk);
    model_step(s, p, gv, ga, pv, pn, mi);
    #1;
    start = 1'b0; pause = 1'b0; gain_valid = 1'b0; pen_valid = 1'b0; miss = 1'b0;
    gain_amt = '0; pen_amt = '0;
    chk_all("mdl", m_state, m_score, m_lives, m_level, m_time, m_lu, m_re);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 4'd0, 0, 4'd0, 0);
  endtask

  // Asynchronous reset applied between clock edges.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    chk_all("rst", 0, 0, NL, 0, TL, 0, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // st pz gv ga pv pn mi | state score lives level time lu re
    tbl[0]  = '{1, 0, 0, 4'd0, 0, 4'd0, 0,  1,  0, 3, 0, 5, 0, 0};
    tbl[1]  = '{0, 0, 1, 4'd9, 0, 4'd0, 0,  1,  9, 3, 0, 5, 0, 0};
    tbl[2]  = '{0, 0, 1, 4'd9, 0, 4'd0, 0,  1, 18, 3, 1, 5, 1, 0};
    tbl[3]  = '{0, 0, 1, 4'd9, 0, 4'd0, 0,  1, 27, 3, 2, 5, 1, 0};
    tbl[4]  = '{0, 0, 1, 4'd9, 0, 4'd0, 0,  3, 30, 3, 3, 4, 1, 1};
    tbl[5]  = '{0, 0, 0, 4'd0, 0, 4'd0, 0,  3, 30, 3, 3, 4, 0, 0};
    tbl[6]  = '{1, 0, 0, 4'd0, 0, 4'd0, 0,  0, 30, 3, 3, 4, 0, 0};
    tbl[7]  = '{1, 0, 0, 4'd0, 0, 4'd0, 0,  1,  0, 3, 0, 5, 0, 0};
    tbl[8]  = '{0, 0, 1, 4'd2, 0, 4'd0, 0,  1,  2, 3, 0, 5, 0, 0};
    tbl[9]  = '{0, 0, 1, 4'd1, 1, 4'd5, 0,  1,  0, 2, 0, 5, 0, 0};
    tbl[10] = '{0, 0, 1, 4'd2, 0, 4'd0, 0,  1,  2, 2, 0, 5, 0, 0};
    tbl[11] = '{0, 0, 1, 4'd1, 1, 4'd5, 1,  1,  0, 1, 0, 4, 0, 0};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].st, tbl[i].pz, tbl[i].gv, tbl[i].ga, tbl[i].pv, tbl[i].pn, tbl[i].mi);
      chk_all($sformatf("vec%0d", i), tbl[i].e_state, tbl[i].e_score, tbl[i].e_lives,
              tbl[i].e_level, tbl[i].e_time, tbl[i].e_lu, tbl[i].e_re);
    end

    // Timeout with no events: 5 ticks of 4 cycles.
    do_reset();
    step(1, 0, 0, 4'd0, 0, 4'd0, 0);
    idle(19);
    chk_all("to19", 1, 0, 3, 0, 1, 0, 0);
    idle(1);
    chk_all("to20", 4, 0, 3, 0, 0, 0, 1);
    idle(1);
    chk_all("to21", 4, 0, 3, 0, 0, 0, 0);

    // Three misses to LOSE, fourth miss changes nothing.
    step(1, 0, 0, 4'd0, 0, 4'd0, 0);
    chk_all("lose_idle", 0, 0, 3, 0, 0, 0, 0);
    step(1, 0, 0, 4'd0, 0, 4'd0, 0);
    step(0, 0, 0, 4'd0, 0, 4'd0, 1);
    chk_all("miss1", 1, 0, 2, 0, 5, 0, 0);
    step(0, 0, 0, 4'd0, 0, 4'd0, 1);
    chk_all("miss2", 1, 0, 1, 0, 5, 0, 0);
    step(0, 0, 0, 4'd0, 0, 4'd0, 1);
    chk_all("miss3", 4, 0, 0, 0, 5, 0, 1);
    step(0, 0, 0, 4'd0, 0, 4'd0, 1);
    chk_all("miss4", 4, 0, 0, 0, 5, 0, 0);

    // Win beats dead on the same edge.
    step(1, 0, 0, 4'd0, 0, 4'd0, 0);
    step(1, 0, 0, 4'd0, 0, 4'd0, 0);
    step(0, 0, 1, 4'd15, 0, 4'd0, 0);
    chk_all("w15", 1, 15, 3, 1, 5, 1, 0);
    step(0, 0, 1, 4'd14, 0, 4'd0, 0);
    chk_all("w29", 1, 29, 3, 2, 5, 1, 0);
    step(0, 0, 0, 4'd0, 0, 4'd0, 1);
    step(0, 0, 0, 4'd0, 0, 4'd0, 1);
    chk_all("w_l1", 1, 29, 1, 2, 4, 0, 0);
    step(0, 0, 1, 4'd1, 0, 4'd0, 1);
    chk_all("w_prio", 3, 30, 0, 3, 4, 1, 1);

    // Pause freezes everything; start from PAUSE returns to IDLE.
    step(1, 0, 0, 4'd0, 0, 4'd0, 0);
    step(1, 0, 0, 4'd0, 0, 4'd0, 0);
    step(0, 0, 1, 4'd5, 0, 4'd0, 0);
    step(0, 1, 0, 4'd0, 0, 4'd0, 0);
    chk_all("p_in", 2, 5, 3, 0, 5, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 4'd9, (i % 3) == 0, 4'd2, (i % 4) == 1);
    chk_all("p_hold", 2, 5, 3, 0, 5, 0, 0);
    step(0, 1, 0, 4'd0, 0, 4'd0, 0);
    chk_all("p_out", 1, 5, 3, 0, 5, 0, 0);
    step(0, 1, 0, 4'd0, 0, 4'd0, 0);
    step(1, 0, 0, 4'd0, 0, 4'd0, 0);
    chk_all("p_idle", 0, 5, 3, 0, 5, 0, 0);

    // Reset in the middle of a round.
    step(1, 0, 0, 4'd0, 0, 4'd0, 0);
    step(0, 0, 1, 4'd9, 0, 4'd0, 0);
    step(0, 0, 1, 4'd9, 0, 4'd0, 0);
    chk_all("mid", 1, 18, 3, 1, 5, 1, 0);
    do_reset();

    // Randomized phase against the model.
    for (int n = 0; n < 4000; n++) begin
      logic s, p, gv, pv, mi;
      logic [3:0] ga, pn;
      if ($urandom_range(699) == 0) do_reset();
      s  = ($urandom_range(11) == 0);
      p  = !s && ($urandom_range(19) == 0);
      gv = ($urandom_range(2) == 0);
      pv = ($urandom_range(4) == 0);
      mi = ($urandom_range(11) == 0);
      ga = 4'($urandom_range(15));
      pn = 4'($urandom_range(15));
      step(s, p, gv, ga, pv, pn, mi);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
